// File: rtl/alu_multibyte_seq_pkg.sv
// Shared encodings for the multi-byte ALU sequencer: command codes, FSM states,
// 8-bit ALU opsel codes, AVR SREG bit positions and command classification.
// Optional feature macro: ALU_SEQ_CMP_EN (enables SEQ_CMD_CMP as a real command).
package alu_multibyte_seq_pkg;

    // Sequencer command codes
    localparam logic [2:0] SEQ_CMD_ADD = 3'd0;
    localparam logic [2:0] SEQ_CMD_SUB = 3'd1;
    localparam logic [2:0] SEQ_CMD_AND = 3'd2;
    localparam logic [2:0] SEQ_CMD_OR  = 3'd3;
    localparam logic [2:0] SEQ_CMD_EOR = 3'd4;
    localparam logic [2:0] SEQ_CMD_CMP = 3'd5;

    typedef enum logic [1:0] {
        SEQ_STATE_IDLE = 2'd0,
        SEQ_STATE_RUN  = 2'd1,
        SEQ_STATE_DONE = 2'd2
    } seq_state_t;

    // 8-bit ALU operation selects
    localparam logic [2:0] OPSEL_ADD = 3'd0;
    localparam logic [2:0] OPSEL_ADC = 3'd1;
    localparam logic [2:0] OPSEL_SUB = 3'd2;  // subtract with borrow-in from flags_in C
    localparam logic [2:0] OPSEL_AND = 3'd3;
    localparam logic [2:0] OPSEL_OR  = 3'd4;
    localparam logic [2:0] OPSEL_EOR = 3'd5;

    // AVR SREG bit positions
    localparam int FLAGS_C = 0;
    localparam int FLAGS_Z = 1;
    localparam int FLAGS_N = 2;
    localparam int FLAGS_V = 3;
    localparam int FLAGS_S = 4;
    localparam int FLAGS_H = 5;
    localparam int FLAGS_T = 6;
    localparam int FLAGS_I = 7;

    typedef enum logic [1:0] {
        OP_CLASS_ARITH = 2'd0,  // writes data, flags from ALU
        OP_CLASS_LOGIC = 2'd1,  // writes data, C/H pass through
        OP_CLASS_CMP   = 2'd2,  // subtract flags only, data untouched
        OP_CLASS_NONE  = 2'd3   // unknown: zero data, SREG passes through
    } op_class_t;

    function automatic op_class_t classify(input logic [2:0] op);
        op_class_t cls;
        cls = OP_CLASS_NONE;
        case (op)
            SEQ_CMD_ADD, SEQ_CMD_SUB:              cls = OP_CLASS_ARITH;
            SEQ_CMD_AND, SEQ_CMD_OR, SEQ_CMD_EOR:  cls = OP_CLASS_LOGIC;
`ifdef ALU_SEQ_CMP_EN
            SEQ_CMD_CMP:                           cls = OP_CLASS_CMP;
`endif
            default:                               cls = OP_CLASS_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/alu_multibyte_seq_alu.sv
// Combinational AVR-style ALU slice. SUB always consumes the incoming C as a
// borrow so the sequencer can chain bytes; logic ops leave C and H untouched.
// With enable low the result is zero and the SREG passes through unchanged.
module alu_multibyte_seq_alu
    import alu_multibyte_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  enable,
    input  logic [2:0]            opsel,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [7:0]            flags_in,
    output logic [DATA_WIDTH-1:0] result,
    output logic [7:0]            flags_out
);
    localparam int MSB = DATA_WIDTH - 1;

    logic                  cin;
    logic [DATA_WIDTH:0]   wide;
    logic [DATA_WIDTH-1:0] res;
    logic [7:0]            flags;
    logic                  v;
    logic                  is_arith;
    logic                  is_logic;

    // Operation decode, result and flag generation
    always_comb begin
        cin      = 1'b0;
        wide     = '0;
        res      = '0;
        flags    = flags_in;
        v        = 1'b0;
        is_arith = 1'b0;
        is_logic = 1'b0;
        if (enable) begin
            case (opsel)
                OPSEL_ADD, OPSEL_ADC: begin
                    cin      = (opsel == OPSEL_ADC) ? flags_in[FLAGS_C] : 1'b0;
                    wide     = {1'b0, a} + {1'b0, b} + {{DATA_WIDTH{1'b0}}, cin};
                    res      = wide[MSB:0];
                    v        = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
                    is_arith = 1'b1;
                end
                OPSEL_SUB: begin
                    cin      = flags_in[FLAGS_C];
                    wide     = {1'b0, a} - {1'b0, b} - {{DATA_WIDTH{1'b0}}, cin};
                    res      = wide[MSB:0];
                    v        = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
                    is_arith = 1'b1;
                end
                OPSEL_AND: begin res = a & b; is_logic = 1'b1; end
                OPSEL_OR:  begin res = a | b; is_logic = 1'b1; end
                OPSEL_EOR: begin res = a ^ b; is_logic = 1'b1; end
                default:   res = '0;
            endcase
            if (is_arith) begin
                flags[FLAGS_C] = wide[DATA_WIDTH];
                // carry/borrow into bit 4 recovered from the sum bits
                flags[FLAGS_H] = a[4] ^ b[4] ^ res[4];
                flags[FLAGS_V] = v;
            end
            if (is_logic) begin
                flags[FLAGS_V] = 1'b0;
            end
            if (is_arith || is_logic) begin
                flags[FLAGS_Z] = (res == '0);
                flags[FLAGS_N] = res[MSB];
                flags[FLAGS_S] = res[MSB] ^ flags[FLAGS_V];
            end
        end
        result    = res;
        flags_out = flags;
    end

endmodule

// File: rtl/alu_multibyte_seq.sv
// Multi-byte ALU sequencer: runs one 8-bit ALU over NUM_BYTES bytes, LSB
// first, chaining carry/borrow and merging per-byte flags into one SREG.
// Optional feature macro: ALU_SEQ_CMP_EN (SEQ_CMD_CMP = SUB flags, data kept).
module alu_multibyte_seq
    import alu_multibyte_seq_pkg::*;
#(
    parameter int NUM_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [NUM_BYTES*8-1:0] cmd_a,
    input  logic [NUM_BYTES*8-1:0] cmd_b,
    input  logic [7:0]             flags_in,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [NUM_BYTES*8-1:0] res_data,
    output logic [7:0]             res_flags,
    output logic                   busy
);
    localparam int              W        = NUM_BYTES * 8;
    localparam int              IDX_W    = $clog2(NUM_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    seq_state_t       state_reg, state_next;
    logic [IDX_W-1:0] idx_reg;
    logic [W-1:0]     a_reg, b_reg;
    logic [W-1:0]     res_data_reg, res_data_next;
    logic [2:0]       op_reg;
    logic [7:0]       flags_reg, res_flags_reg;
    logic             carry_reg;
    logic             zero_reg;

    op_class_t        op_class;
    logic             first_byte, last_byte, run, write_en;
    logic [7:0]       a_bytes [NUM_BYTES];
    logic [7:0]       b_bytes [NUM_BYTES];
    logic [7:0]       byte_a, byte_b, byte_val;
    logic [7:0]       alu_result, alu_flags_in, alu_flags_out, merged_flags;
    logic [2:0]       alu_opsel;

    assign op_class   = classify(op_reg);
    assign first_byte = (idx_reg == '0);
    assign last_byte  = (idx_reg == LAST_IDX);
    assign run        = (state_reg == SEQ_STATE_RUN);
    // compare leaves the previous result in place
    assign write_en   = run && (op_class != OP_CLASS_CMP);
    assign byte_val   = (op_class == OP_CLASS_NONE) ? 8'h00 : alu_result;

    // Byte views of the latched operands and per-byte result update
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_bytes
        assign a_bytes[gi] = a_reg[gi*8 +: 8];
        assign b_bytes[gi] = b_reg[gi*8 +: 8];
        assign res_data_next[gi*8 +: 8] =
            (write_en && (idx_reg == IDX_W'(gi))) ? byte_val : res_data_reg[gi*8 +: 8];
    end

    assign byte_a = a_bytes[idx_reg];
    assign byte_b = b_bytes[idx_reg];

    // ALU opsel and carry-in selection for the current byte
    always_comb begin
        alu_opsel    = OPSEL_AND;
        alu_flags_in = flags_reg;
        case (op_reg)
            SEQ_CMD_ADD: begin
                alu_opsel               = first_byte ? OPSEL_ADD : OPSEL_ADC;
                alu_flags_in[FLAGS_C]   = carry_reg;
            end
            SEQ_CMD_SUB, SEQ_CMD_CMP: begin
                // byte 0 must not see the caller's C as a borrow
                alu_opsel               = OPSEL_SUB;
                alu_flags_in[FLAGS_C]   = first_byte ? 1'b0 : carry_reg;
            end
            SEQ_CMD_AND: alu_opsel = OPSEL_AND;
            SEQ_CMD_OR:  alu_opsel = OPSEL_OR;
            SEQ_CMD_EOR: alu_opsel = OPSEL_EOR;
            default:     alu_opsel = OPSEL_AND;
        endcase
    end

    alu_multibyte_seq_alu #(
        .DATA_WIDTH (8)
    ) u_alu (
        .enable    (1'b1),
        .opsel     (alu_opsel),
        .a         (byte_a),
        .b         (byte_b),
        .flags_in  (alu_flags_in),
        .result    (alu_result),
        .flags_out (alu_flags_out)
    );

    // Final SREG: last byte's flags with Z accumulated over all bytes
    always_comb begin
        merged_flags = alu_flags_out;
        merged_flags[FLAGS_Z] = zero_reg & alu_flags_out[FLAGS_Z];
        if (op_class == OP_CLASS_NONE) begin
            merged_flags = flags_reg;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= SEQ_STATE_IDLE;
        else        state_reg <= state_next;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        res_valid  = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            SEQ_STATE_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_next = SEQ_STATE_RUN;
            end
            SEQ_STATE_RUN: begin
                busy = 1'b1;
                if (last_byte) state_next = SEQ_STATE_DONE;
            end
            SEQ_STATE_DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) state_next = SEQ_STATE_IDLE;
            end
            default: state_next = SEQ_STATE_IDLE;
        endcase
    end

    // Command latch, byte counter, carry/zero chain and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_reg       <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            op_reg        <= '0;
            flags_reg     <= '0;
            carry_reg     <= 1'b0;
            zero_reg      <= 1'b1;
            res_data_reg  <= '0;
            res_flags_reg <= '0;
        end else begin
            res_data_reg <= res_data_next;
            if (state_reg == SEQ_STATE_IDLE && cmd_valid) begin
                a_reg     <= cmd_a;
                b_reg     <= cmd_b;
                op_reg    <= cmd_op;
                flags_reg <= flags_in;
                idx_reg   <= '0;
                carry_reg <= 1'b0;
                zero_reg  <= 1'b1;
            end else if (run) begin
                carry_reg <= alu_flags_out[FLAGS_C];
                zero_reg  <= zero_reg & alu_flags_out[FLAGS_Z];
                if (last_byte) res_flags_reg <= merged_flags;
                else           idx_reg       <= idx_reg + IDX_W'(1);
            end
        end
    end

    assign res_data  = res_data_reg;
    assign res_flags = res_flags_reg;

endmodule

// File: tb/tb_alu_multibyte_seq.sv
// Self-checking bench for alu_multibyte_seq (NUM_BYTES=4): directed cases
// followed by randomized commands checked against a word-level model.
module tb_alu_multibyte_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, res_valid, res_ready, busy;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_a, cmd_b, res_data;
    logic [7:0]  flags_in, res_flags;

    int          checks = 0;
    int          passed = 0;
    int          fails  = 0;
    logic [31:0] prev_data = 32'h0;

`ifdef ALU_SEQ_CMP_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    alu_multibyte_seq #(.NUM_BYTES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .flags_in  (flags_in),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_flags (res_flags),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Whole-word reference: returns {flags, data}
    function automatic logic [39:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [7:0] fi,
                                          input logic [31:0] prev);
        logic [32:0] s;
        logic [28:0] lo;
        logic [31:0] r;
        logic [7:0]  f;
        logic        v;
        f = fi;
        r = 32'h0;
        if (op == 3'd0) begin
            s  = {1'b0, a} + {1'b0, b};
            lo = {1'b0, a[27:0]} + {1'b0, b[27:0]};
            r  = s[31:0];
            v  = (a[31] == b[31]) && (r[31] != a[31]);
            f[0] = s[32]; f[5] = lo[28];
            f[1] = (r == 32'h0); f[2] = r[31]; f[3] = v; f[4] = r[31] ^ v;
        end else if (op == 3'd1 || (CMP_EN && op == 3'd5)) begin
            r  = a - b;
            v  = (a[31] != b[31]) && (r[31] != a[31]);
            f[0] = (a < b); f[5] = (a[27:0] < b[27:0]);
            f[1] = (r == 32'h0); f[2] = r[31]; f[3] = v; f[4] = r[31] ^ v;
            if (op == 3'd5) r = prev;
        end else if (op == 3'd2 || op == 3'd3 || op == 3'd4) begin
            r = (op == 3'd2) ? (a & b) : (op == 3'd3) ? (a | b) : (a ^ b);
            f[1] = (r == 32'h0); f[2] = r[31]; f[3] = 1'b0; f[4] = r[31];
        end
        return {f, r};
    endfunction

    // One full command: issue, latency, result, optional DONE hold, release
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [7:0] fl, input int hold);
        logic [39:0] exp;
        int n;
        exp = model(op, a, b, fl, prev_data);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; flags_in = fl;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check("accept_bound", 64'(n < 20), 64'(1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 1;
        while (res_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        $display("op=%0d a=%h b=%h fi=%h -> data=%h flags=%h lat=%0d", op, a, b, fl,
                 res_data, res_flags, n);
        check("latency", 64'(n), 64'(5));
        check("res_data", 64'(res_data), 64'(exp[31:0]));
        check("res_flags", 64'(res_flags), 64'(exp[39:32]));
        check("busy_done", 64'(busy), 64'(1));
        check("cmd_ready_done", 64'(cmd_ready), 64'(0));
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1; cmd_op = 3'd3; cmd_a = ~a; cmd_b = ~b;
            @(posedge clk); #1;
            check("hold_valid", 64'(res_valid), 64'(1));
            check("hold_ready", 64'(cmd_ready), 64'(0));
            check("hold_data", 64'(res_data), 64'(exp[31:0]));
            check("hold_flags", 64'(res_flags), 64'(exp[39:32]));
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("valid_drop", 64'(res_valid), 64'(0));
        check("ready_back", 64'(cmd_ready), 64'(1));
        prev_data = exp[31:0];
    endtask

    initial begin
        logic seen;
        rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_op = 3'd0; cmd_a = 32'h0; cmd_b = 32'h0; flags_in = 8'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rst_res_valid", 64'(res_valid), 64'(0));
        check("rst_res_data", 64'(res_data), 64'(0));
        check("rst_res_flags", 64'(res_flags), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));

        // directed cases with hand-derived constants
        run_op(3'd0, 32'h00FFFFFF, 32'h00000001, 8'h00, 0);
        check("add_carry_chain", 64'({res_data, res_flags}), 64'({32'h01000000, 8'h00}));
        run_op(3'd0, 32'hFFFFFFFF, 32'h00000001, 8'h00, 0);
        check("add_wrap", 64'({res_data, res_flags}), 64'({32'h00000000, 8'h23}));
        run_op(3'd1, 32'h00000000, 32'h00000001, 8'h00, 0);
        check("sub_wrap", 64'({res_data, res_flags}), 64'({32'hFFFFFFFF, 8'h35}));
        run_op(3'd1, 32'h00000100, 32'h00000001, 8'h01, 0);
        check("sub_c_forced", 64'({res_data, res_flags}), 64'({32'h000000FF, 8'h00}));
        run_op(3'd2, 32'hF0F00000, 32'h0F0FFFFF, 8'h41, 3);
        check("and_zero", 64'({res_data, res_flags}), 64'({32'h00000000, 8'h43}));
        run_op(3'd6, 32'h12345678, 32'h11111111, 8'hA5, 1);
        check("undef_op", 64'({res_data, res_flags}), 64'({32'h00000000, 8'hA5}));

        // reset while the third byte is being processed
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 32'h12345678; cmd_b = 32'h01010101;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("run_busy", 64'(busy), 64'(1));
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_ready", 64'(cmd_ready), 64'(1));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_data", 64'(res_data), 64'(0));
        seen = res_valid;
        repeat (6) begin @(posedge clk); #1; seen = seen | res_valid; end
        check("midrst_no_valid", 64'(seen), 64'(0));
        prev_data = 32'h0;
        run_op(3'd0, 32'h00000001, 32'h00000001, 8'h00, 0);
        check("post_rst_add", 64'(res_data), 64'(2));

        // randomized commands, including undefined codes and DONE holds
        for (int k = 0; k < 40; k++) begin
            run_op(3'($urandom_range(0, 7)), $urandom, $urandom, 8'($urandom),
                   int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
